alut_lookup_master: RTL

ALUT_LOOKUP_MASTER -- requirements
Module: alut_lookup_master

---
 rtl/alut_lookup_master.sv | 295 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/alut_lookup_master.sv
`default_nettype none
// ============================================================================
// Module   : alut_lookup_master
// Purpose  : Turns one Ethernet header request into an ALUT address lookup.
//            It acts as an APB master (no pready): it writes the destination
//            MAC, the source MAC and the source port, then issues the lookup
//            command. After a two-cycle gap it polls STATUS until the busy
//            bit clears, reads DPORT and returns the one-hot destination
//            port. If the busy bit is still set after POLL_MAX STATUS reads,
//            it returns a timeout result instead.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   pclk         in   1   clock, all state on rising edge
//   n_p_reset    in   1   synchronous active-low reset
//   hdr_valid    in   1   header request valid
//   hdr_ready    out  1   block idle and can accept a header
//   hdr_daddr    in  48   destination MAC
//   hdr_saddr    in  48   source MAC
//   hdr_sport    in   2   source port
//   res_valid    out  1   lookup result valid
//   res_ready    in   1   consumer accepts result
//   res_dport    out  5   destination port, one-hot (bit4 = switch MAC)
//   res_timeout  out  1   lookup timed out
//   psel/penable/pwrite out 1, paddr out 7, pwdata out 32, prdata in 32
// ============================================================================
module alut_lookup_master #(
    parameter logic [6:0] CMD_ADDR      = 7'h00,
    parameter logic [6:0] DADDR_LO_ADDR = 7'h08,
    parameter logic [6:0] DADDR_HI_ADDR = 7'h0C,
    parameter logic [6:0] SADDR_LO_ADDR = 7'h10,
    parameter logic [6:0] SADDR_HI_ADDR = 7'h14,
    parameter logic [6:0] STATUS_ADDR   = 7'h18,
    parameter logic [6:0] DPORT_ADDR    = 7'h1C,
    parameter int         POLL_MAX      = 64
) (
    input  logic        pclk,
    input  logic        n_p_reset,
    input  logic        hdr_valid,
    output logic        hdr_ready,
    input  logic [47:0] hdr_daddr,
    input  logic [47:0] hdr_saddr,
    input  logic [1:0]  hdr_sport,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [4:0]  res_dport,
    output logic        res_timeout,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [6:0]  paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_ACCESS = 3'd2,
        S_GAP    = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    // Transfer step index: the five writes, then the STATUS and DPORT reads.
    localparam logic [2:0] C_STEP_DLO   = 3'd0;
    localparam logic [2:0] C_STEP_DHI   = 3'd1;
    localparam logic [2:0] C_STEP_SLO   = 3'd2;
    localparam logic [2:0] C_STEP_SHI   = 3'd3;
    localparam logic [2:0] C_STEP_CMD   = 3'd4;
    localparam logic [2:0] C_STEP_STAT  = 3'd5;
    localparam logic [2:0] C_STEP_DPORT = 3'd6;

    localparam logic [7:0] C_POLL_MAX = 8'(POLL_MAX);

    state_t      r_state;
    logic [2:0]  r_step;
    logic        r_gap;
    logic [7:0]  r_poll_cnt;
    logic [47:0] r_daddr;
    logic [47:0] r_saddr;
    logic [1:0]  r_sport;
    logic        r_psel;
    logic        r_penable;
    logic        r_pwrite;
    logic [6:0]  r_paddr;
    logic [31:0] r_pwdata;
    logic        r_res_valid;
    logic [4:0]  r_res_dport;
    logic        r_res_timeout;

    state_t      w_state_nxt;
    logic [2:0]  w_step_nxt;
    logic        w_gap_nxt;
    logic [7:0]  w_poll_nxt;
    logic [7:0]  w_poll_inc;
    logic [4:0]  w_dport_nxt;
    logic        w_timeout_nxt;
    logic        w_capture;
    logic        w_xfer;
    logic        w_pwrite_nxt;
    logic [6:0]  w_paddr_nxt;
    logic [31:0] w_pwdata_nxt;
    logic [47:0] w_daddr_src;
    logic [47:0] w_saddr_src;
    logic [1:0]  w_sport_src;

    // Only the busy bit and the port field of the read data are meaningful.
    logic        w_unused_prdata;
    assign w_unused_prdata = ^prdata[31:5];

    assign hdr_ready = (r_state == S_IDLE) && n_p_reset;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_step_nxt    = r_step;
        w_gap_nxt     = r_gap;
        w_poll_nxt    = r_poll_cnt;
        w_poll_inc    = r_poll_cnt + 8'd1;
        w_dport_nxt   = r_res_dport;
        w_timeout_nxt = r_res_timeout;
        w_capture     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (hdr_valid && hdr_ready) begin
                    w_capture     = 1'b1;
                    w_state_nxt   = S_SETUP;
                    w_step_nxt    = C_STEP_DLO;
                    w_poll_nxt    = 8'd0;
                    w_dport_nxt   = 5'd0;
                    w_timeout_nxt = 1'b0;
                end
            end
            S_SETUP: begin
                w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                case (r_step)
                    C_STEP_CMD: begin
                        w_state_nxt = S_GAP;
                        w_gap_nxt   = 1'b0;
                    end
                    C_STEP_STAT: begin
                        w_poll_nxt = w_poll_inc;
                        if (!prdata[0]) begin
                            w_state_nxt = S_SETUP;
                            w_step_nxt  = C_STEP_DPORT;
                        end else if (w_poll_inc >= C_POLL_MAX) begin
                            // Still busy after the last allowed poll.
                            w_state_nxt   = S_RESP;
                            w_timeout_nxt = 1'b1;
                            w_dport_nxt   = 5'd0;
                        end else begin
                            w_state_nxt = S_SETUP;
                        end
                    end
                    C_STEP_DPORT: begin
                        w_state_nxt   = S_RESP;
                        w_dport_nxt   = prdata[4:0];
                        w_timeout_nxt = 1'b0;
                    end
                    default: begin
                        w_state_nxt = S_SETUP;
                        w_step_nxt  = r_step + 3'd1;
                    end
                endcase
            end
            S_GAP: begin
                if (r_gap) begin
                    w_state_nxt = S_SETUP;
                    w_step_nxt  = C_STEP_STAT;
                end else begin
                    w_gap_nxt = 1'b1;
                end
            end
            S_RESP: begin
                if (res_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bus outputs are decoded from the next state and step, then
    // registered, so the pins change exactly on the cycle boundary and
    // stay constant across SETUP and ACCESS of one transfer.
    // ------------------------------------------------------------------
    always_comb begin
        // On the accept edge the header registers are not loaded yet.
        w_daddr_src  = w_capture ? hdr_daddr : r_daddr;
        w_saddr_src  = w_capture ? hdr_saddr : r_saddr;
        w_sport_src  = w_capture ? hdr_sport : r_sport;
        w_xfer       = (w_state_nxt == S_SETUP) || (w_state_nxt == S_ACCESS);
        w_pwrite_nxt = 1'b0;
        w_paddr_nxt  = 7'd0;
        w_pwdata_nxt = 32'd0;
        if (w_xfer) begin
            case (w_step_nxt)
                C_STEP_DLO: begin
                    w_pwrite_nxt = 1'b1;
                    w_paddr_nxt  = DADDR_LO_ADDR;
                    w_pwdata_nxt = w_daddr_src[31:0];
                end
                C_STEP_DHI: begin
                    w_pwrite_nxt = 1'b1;
                    w_paddr_nxt  = DADDR_HI_ADDR;
                    w_pwdata_nxt = {16'h0000, w_daddr_src[47:32]};
                end
                C_STEP_SLO: begin
                    w_pwrite_nxt = 1'b1;
                    w_paddr_nxt  = SADDR_LO_ADDR;
                    w_pwdata_nxt = w_saddr_src[31:0];
                end
                C_STEP_SHI: begin
                    w_pwrite_nxt = 1'b1;
                    w_paddr_nxt  = SADDR_HI_ADDR;
                    w_pwdata_nxt = {14'h0000, w_sport_src, w_saddr_src[47:32]};
                end
                C_STEP_CMD: begin
                    w_pwrite_nxt = 1'b1;
                    w_paddr_nxt  = CMD_ADDR;
                    w_pwdata_nxt = 32'h0000_0001;
                end
                C_STEP_STAT: begin
                    w_paddr_nxt = STATUS_ADDR;
                end
                C_STEP_DPORT: begin
                    w_paddr_nxt = DPORT_ADDR;
                end
                default: begin
                    w_paddr_nxt = 7'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (!n_p_reset) begin
            r_state       <= S_IDLE;
            r_step        <= C_STEP_DLO;
            r_gap         <= 1'b0;
            r_poll_cnt    <= 8'd0;
            r_daddr       <= 48'd0;
            r_saddr       <= 48'd0;
            r_sport       <= 2'd0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= 7'd0;
            r_pwdata      <= 32'd0;
            r_res_valid   <= 1'b0;
            r_res_dport   <= 5'd0;
            r_res_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_step        <= w_step_nxt;
            r_gap         <= w_gap_nxt;
            r_poll_cnt    <= w_poll_nxt;
            if (w_capture) begin
                r_daddr <= hdr_daddr;
                r_saddr <= hdr_saddr;
                r_sport <= hdr_sport;
            end
            r_psel        <= w_xfer;
            r_penable     <= (w_state_nxt == S_ACCESS);
            r_pwrite      <= w_pwrite_nxt;
            r_paddr       <= w_paddr_nxt;
            r_pwdata      <= w_pwdata_nxt;
            r_res_valid   <= (w_state_nxt == S_RESP);
            r_res_dport   <= w_dport_nxt;
            r_res_timeout <= w_timeout_nxt;
        end
    end

    assign psel        = r_psel;
    assign penable     = r_penable;
    assign pwrite      = r_pwrite;
    assign paddr       = r_paddr;
    assign pwdata      = r_pwdata;
    assign res_valid   = r_res_valid;
    assign res_dport   = r_res_dport;
    assign res_timeout = r_res_timeout;

endmodule
`default_nettype wire
